// File: rtl/sdf_twiddle_mul.sv
// Twiddle-factor rotation stage for the radix-2^2 SDF FFT.
// Each streamed sample n is multiplied by W_N^k, where k = bitrev2(n / (N/4)) * (n mod N/4).
// The result is rounded half toward +inf and saturated to WIDTH bits.
// The pipeline has three register stages: inputs+ROM, products, then sum/round/saturate.
module sdf_twiddle_mul #(
  parameter int N        = 64,
  parameter int WIDTH    = 8,
  parameter int TW_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_in,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    enable_out,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int  LN     = $clog2(N);
  localparam int  F      = TW_WIDTH - 2;
  localparam int  PW     = WIDTH + TW_WIDTH;
  localparam int  SW     = PW + 1;
  localparam int  STAGES = 3;
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [SW-1:0] HALF = SW'(2 ** (F - 1));
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (WIDTH - 1)));

  // Twiddle ROM. Each entry is computed at elaboration and rounded to nearest.
  // Entry k = 0 comes out as exactly c = 2^F, s = 0.
  logic signed [TW_WIDTH-1:0] rom_c [N];
  logic signed [TW_WIDTH-1:0] rom_s [N];

  for (genvar gk = 0; gk < N; gk++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(gk) / real'(N);
    localparam int  CI  = $rtoi($floor($cos(ANG) * real'(2 ** F) + 0.5));
    localparam int  SI  = $rtoi($floor($sin(ANG) * real'(2 ** F) + 0.5));
    assign rom_c[gk] = TW_WIDTH'(CI);
    assign rom_s[gk] = TW_WIDTH'(SI);
  end

  // Position within the frame. Any idle cycle restarts the frame at index 0.
  logic [LN-1:0] cnt;

  // Sample counter: wraps at N and clears on any enable_in-low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (enable_in) cnt <= cnt + LN'(1);
    else                cnt <= '0;
  end

  // Twiddle index: the quadrant bits are swapped (bit-reversed), then multiplied by the offset in the sub-block.
  logic [1:0]    q, qr;
  logic [LN-3:0] m;
  logic [LN-1:0] k;

  assign q  = cnt[LN-1:LN-2];
  assign qr = {q[0], q[1]};
  assign m  = cnt[LN-3:0];
  assign k  = {{(LN-2){1'b0}}, qr} * {2'b00, m};

  logic [STAGES-1:0]          vld_pipe;
  logic signed [WIDTH-1:0]    a1, b1;
  logic signed [TW_WIDTH-1:0] c1, s1;
  logic signed [PW-1:0]       p_ac, p_bs, p_bc, p_as;

  // Valid shift register. It tracks the data stages one for one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], enable_in};
  end

  assign enable_out = vld_pipe[STAGES-1];

  // Stage 1: capture the sample together with its twiddle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1 <= '0; b1 <= '0; c1 <= '0; s1 <= '0;
    end else begin
      a1 <= in_re;
      b1 <= in_im;
      c1 <= rom_c[k];
      s1 <= rom_s[k];
    end
  end

  // Stage 2: full-precision products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ac <= '0; p_bs <= '0; p_bc <= '0; p_as <= '0;
    end else begin
      p_ac <= PW'(a1) * PW'(c1);
      p_bs <= PW'(b1) * PW'(s1);
      p_bc <= PW'(b1) * PW'(c1);
      p_as <= PW'(a1) * PW'(s1);
    end
  end

  // Round half toward +inf, drop the F fraction bits, then clamp to WIDTH.
  function automatic logic signed [WIDTH-1:0] rnd_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] r;
    r = (s + HALF) >>> F;
    if (r > MAXV)      return MAXV[WIDTH-1:0];
    else if (r < MINV) return MINV[WIDTH-1:0];
    else               return r[WIDTH-1:0];
  endfunction

  logic signed [SW-1:0] sum_re, sum_im;

  // Complex multiply by (c - j*s): re = a*c + b*s, im = b*c - a*s.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    sum_re = {p_ac[PW-1], p_ac} + {p_bs[PW-1], p_bs};
    sum_im = {p_bc[PW-1], p_bc} - {p_as[PW-1], p_as};
  end

  // Stage 3: the outputs update only for valid samples and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re <= '0;
      out_im <= '0;
    end else if (vld_pipe[STAGES-2]) begin
      out_re <= rnd_sat(sum_re);
      out_im <= rnd_sat(sum_im);
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_mul.sv
// Randomised and directed bench for sdf_twiddle_mul.
// It holds a reference model with the twiddle rule, rounding, saturation and 3-cycle latency.
module tb_sdf_twiddle_mul;

  localparam int  N     = 64;
  localparam int  WIDTH = 8;
  localparam int  TW    = 8;
  localparam real PI    = 3.14159265358979323846;
  localparam real ONE   = 64.0;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable_in;
  logic signed [WIDTH-1:0] in_re, in_im;
  logic                    enable_out;
  logic signed [WIDTH-1:0] out_re, out_im;

  sdf_twiddle_mul #(.N(N), .WIDTH(WIDTH), .TW_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .in_re(in_re), .in_im(in_im),
    .enable_out(enable_out), .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int re;
    int im;
    bit d;
    int dre;
    int dim;
  } ent_t;

  ent_t pipe[$];
  int   mcnt = 0;
  int   exp_re = 0, exp_im = 0;
  bit   exp_en = 1'b0;
  int   checks = 0, errors = 0;

  function automatic int twiddle_k(int n);
    int qr[4] = '{0, 2, 1, 3};
    return qr[n / (N / 4)] * (n % (N / 4));
  endfunction

  function automatic int sat_round(int raw);
    int r;
    r = $rtoi($floor((real'(raw) + ONE / 2.0) / ONE));
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic void model(input int n, input int a, input int b, output int re, output int im);
    int k, c, s;
    k  = twiddle_k(n);
    c  = $rtoi($floor($cos(2.0 * PI * k / N) * ONE + 0.5));
    s  = $rtoi($floor($sin(2.0 * PI * k / N) * ONE + 0.5));
    re = sat_round(a * c + b * s);
    im = sat_round(b * c - a * s);
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input int expv);
    checks++;
    assert (got === WIDTH'(expv))
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), expv);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input bit expv);
    checks++;
    assert (got === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, expv);
    end
  endtask

  // Drive one cycle, advance the model, then compare the outputs after the edge.
  task automatic step(input bit en, input int a, input int b,
                      input bit d = 1'b0, input int dre = 0, input int dim = 0);
    ent_t e;
    int   idx;
    enable_in = en;
    in_re     = WIDTH'(a);
    in_im     = WIDTH'(b);
    e.v = en; e.d = d; e.dre = dre; e.dim = dim; e.re = 0; e.im = 0;
    if (en) begin
      idx  = mcnt;
      mcnt = (mcnt + 1) % N;
      model(idx, a, b, e.re, e.im);
    end else begin
      mcnt = 0;
    end
    pipe.push_back(e);
    @(posedge clk);
    #1;
    exp_en = 1'b0;
    if (pipe.size() == 3) begin
      e = pipe.pop_front();
      if (e.v) begin
        exp_en = 1'b1;
        exp_re = e.re;
        exp_im = e.im;
        if (e.d) begin
          chk("directed_re", out_re, e.dre);
          chk("directed_im", out_im, e.dim);
        end
      end
    end
    chk_bit("enable_out", enable_out, exp_en);
    chk("out_re", out_re, exp_re);
    chk("out_im", out_im, exp_im);
  endtask

  function automatic int rnd();
    return int'($urandom_range(255)) - 128;
  endfunction

  initial begin
    int a, b;
    rst_n = 1'b0; enable_in = 1'b0; in_re = '0; in_im = '0;
    #23;
    chk_bit("reset_en", enable_out, 1'b0);
    chk("reset_re", out_re, 0);
    chk("reset_im", out_im, 0);
    rst_n = 1'b1;

    // Frame 1: identity for n = 0..15, -j rotation at n = 24, saturation at n = 40.
    for (int n = 0; n < N; n++) begin
      if (n < 16)       step(1'b1, 37, -100, 1'b1, 37, -100);
      else if (n == 24) step(1'b1, 10, 20, 1'b1, 20, -10);
      else if (n == 40) step(1'b1, 127, 127, 1'b1, 127, 0);
      else              step(1'b1, rnd(), rnd());
    end

    // Two random frames back to back, with no gap.
    for (int n = 0; n < 2 * N; n++) step(1'b1, rnd(), rnd());

    // A partial frame, a one-cycle gap, then a full frame that restarts at k = 0.
    for (int n = 0; n < N; n++) step(1'b1, rnd(), rnd());
    for (int n = 0; n <= 30; n++) step(1'b1, rnd(), rnd());
    step(1'b0, 0, 0);
    a = rnd(); b = rnd();
    step(1'b1, a, b, 1'b1, a, b);
    for (int n = 1; n < N; n++) step(1'b1, rnd(), rnd());

    // Idle cycles: the outputs must hold their last values.
    for (int n = 0; n < 5; n++) step(1'b0, rnd(), rnd());

    // Asynchronous reset in the middle of a frame.
    for (int n = 0; n < 20; n++) step(1'b1, rnd(), rnd());
    rst_n = 1'b0;
    #2;
    chk_bit("midrst_en", enable_out, 1'b0);
    chk("midrst_re", out_re, 0);
    chk("midrst_im", out_im, 0);
    pipe.delete();
    mcnt = 0; exp_re = 0; exp_im = 0; exp_en = 1'b0;
    #2;
    rst_n = 1'b1;
    a = rnd(); b = rnd();
    step(1'b1, a, b, 1'b1, a, b);
    for (int n = 1; n < N; n++) step(1'b1, rnd(), rnd());
    for (int n = 0; n < 4; n++) step(1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
